// File: rtl/ula_seq_if.sv
// Request/response bundle for the sequential ALU: operands and opcode in,
// registered result, NZCV flags and unsigned compare outputs back.
interface ula_seq_if #(parameter int WIDTH = 4);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       ALUControl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             negative;
   logic             hs;
   logic             ls;
   logic             hi;
   logic             lo;

   modport master (
      output in_valid, a, b, ALUControl, out_ready,
      input  in_ready, out_valid, result, zero, carry, overflow, negative,
             hs, ls, hi, lo
   );

   modport slave (
      input  in_valid, a, b, ALUControl, out_ready,
      output in_ready, out_valid, result, zero, carry, overflow, negative,
             hs, ls, hi, lo
   );
endinterface

// File: rtl/ula_seq.sv
// Registered ALU: single-cycle add/sub/logic/slt, iterative shift-add multiply
// and restoring divide; result and flags held until the consumer takes them.
module ula_seq #(
   parameter int WIDTH = 4
) (
   input logic      clk,
   input logic      rst_n,
   ula_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int M  = WIDTH - 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             isMul_q;
   logic [WIDTH-1:0] operand_q;
   logic [WIDTH-1:0] accHi_q;
   logic [WIDTH-1:0] accLo_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q, carry_q, overflow_q, negative_q;

   logic [WIDTH:0]   addFull, subFull;
   logic             addV, subV;
   logic [WIDTH-1:0] aluRes;
   logic             aluC, aluV;

   assign addFull = {1'b0, bus.a} + {1'b0, bus.b};
   assign subFull = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
   assign addV    = (bus.a[M] == bus.b[M]) && (addFull[M] != bus.a[M]);
   assign subV    = (bus.a[M] != bus.b[M]) && (subFull[M] != bus.a[M]);

   // slt reports the subtraction's C/V so the unsigned compare outputs stay usable
   always_comb begin
      aluRes = '0;
      aluC   = 1'b0;
      aluV   = 1'b0;
      case (bus.ALUControl)
         3'b000:  begin aluRes = addFull[M:0]; aluC = addFull[WIDTH]; aluV = addV; end
         3'b001:  begin aluRes = subFull[M:0]; aluC = subFull[WIDTH]; aluV = subV; end
         3'b010:  aluRes = bus.a & bus.b;
         3'b011:  aluRes = bus.a | bus.b;
         3'b100:  aluRes = bus.a ^ bus.b;
         3'b101:  begin
            aluRes = {{(WIDTH-1){1'b0}}, subFull[M] ^ subV};
            aluC   = subFull[WIDTH];
            aluV   = subV;
         end
         default: aluRes = '0;
      endcase
   end

   logic [WIDTH:0]   mulSum;
   logic [WIDTH-1:0] mulHi, mulLo;
   logic [WIDTH:0]   divShift, divTrial;
   logic             divFits, divZero;
   logic [WIDTH-1:0] divR, divQ;
   logic [WIDTH-1:0] iterRes;
   logic             iterC, iterV;

   // Multiply: {accHi,accLo} holds {partial product, remaining multiplier}.
   // Divide: accHi is the remainder, accLo shifts dividend bits out and quotient bits in.
   assign mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, operand_q} : '0);
   assign mulHi    = mulSum[WIDTH:1];
   assign mulLo    = {mulSum[0], accLo_q[M:1]};
   assign divShift = {accHi_q, accLo_q[M]};
   assign divTrial = divShift - {1'b0, operand_q};
   assign divFits  = ~divTrial[WIDTH];
   assign divZero  = (operand_q == '0);
   assign divR     = divFits ? divTrial[M:0] : divShift[M:0];
   assign divQ     = {accLo_q[M-1:0], divFits};
   assign iterRes  = isMul_q ? mulLo : (divZero ? '1 : divQ);
   assign iterC    = isMul_q && (mulHi != '0);
   assign iterV    = !isMul_q && divZero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         isMul_q    <= 1'b0;
         operand_q  <= '0;
         accHi_q    <= '0;
         accLo_q    <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         negative_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  if (bus.ALUControl[2:1] == 2'b11) begin
                     isMul_q   <= ~bus.ALUControl[0];
                     operand_q <= bus.ALUControl[0] ? bus.b : bus.a;
                     accLo_q   <= bus.ALUControl[0] ? bus.a : bus.b;
                     accHi_q   <= '0;
                     cnt_q     <= '0;
                     state_q   <= BUSY;
                  end else begin
                     result_q   <= aluRes;
                     zero_q     <= (aluRes == '0);
                     negative_q <= aluRes[M];
                     carry_q    <= aluC;
                     overflow_q <= aluV;
                     state_q    <= DONE;
                  end
               end
            end
            BUSY: begin
               accHi_q <= isMul_q ? mulHi : divR;
               accLo_q <= isMul_q ? mulLo : divQ;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  result_q   <= iterRes;
                  zero_q     <= (iterRes == '0);
                  negative_q <= iterRes[M];
                  carry_q    <= iterC;
                  overflow_q <= iterV;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.negative  = negative_q;
   assign bus.hs        = carry_q;
   assign bus.ls        = ~carry_q | zero_q;
   assign bus.hi        = carry_q & ~zero_q;
   assign bus.lo        = ~carry_q;
endmodule

// File: tb/tb_ula_seq.sv
// Directed scoreboard bench for ula_seq at WIDTH=4: each request pushes a
// model-derived expectation that is popped and asserted when out_valid rises.
module tb_ula_seq;
   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   ula_seq_if #(.WIDTH(W)) bus ();

   ula_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        tag;
      logic [W-1:0] res;
      logic         z, c, v, n;
      int           lat;
   } exp_t;

   exp_t sb[$];

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Independent integer model of the ALU behaviour
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input string tag);
      exp_t e;
      int ua, ub, sa, sb2, r, s;
      ua  = int'(a);
      ub  = int'(b);
      sa  = int'($signed(a));
      sb2 = int'($signed(b));
      r   = 0;
      e.tag = tag;
      e.c   = 1'b0;
      e.v   = 1'b0;
      e.lat = 1;
      case (op)
         3'd0: begin r = ua + ub; e.c = (r > 15); s = sa + sb2; e.v = (s > 7) || (s < -8); end
         3'd1: begin r = ua - ub; e.c = (ua >= ub); s = sa - sb2; e.v = (s > 7) || (s < -8); end
         3'd2: r = int'(a & b);
         3'd3: r = int'(a | b);
         3'd4: r = int'(a ^ b);
         3'd5: begin r = (sa < sb2) ? 1 : 0; e.c = (ua >= ub); s = sa - sb2; e.v = (s > 7) || (s < -8); end
         3'd6: begin r = ua * ub; e.c = (r > 15); e.lat = W + 1; end
         default: begin
            if (ub == 0) begin r = 15; e.v = 1'b1; end
            else r = ua / ub;
            e.lat = W + 1;
         end
      endcase
      e.res = W'(r & 15);
      e.z   = (e.res == '0);
      e.n   = e.res[W-1];
      return e;
   endfunction

   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input string tag);
      int guard;
      guard = 0;
      bus.in_valid   = 1'b1;
      bus.a          = a;
      bus.b          = b;
      bus.ALUControl = op;
      while (bus.in_ready !== 1'b1 && guard < 40) begin
         @(posedge clk); #1; guard++;
      end
      sb.push_back(model(op, a, b, tag));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic checkFlags(input exp_t e);
      checkVal({e.tag, "_result"}, bus.result, e.res);
      checkVal({e.tag, "_znvc"}, {bus.zero, bus.negative, bus.overflow, bus.carry},
               {e.z, e.n, e.v, e.c});
      checkVal({e.tag, "_cmp"}, {bus.hs, bus.ls, bus.hi, bus.lo},
               {e.c, ~e.c | e.z, e.c & ~e.z, ~e.c});
   endtask

   task automatic checkOutput(input int holdCycles);
      exp_t e;
      int   lat;
      e   = sb.pop_front();
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      checkVal({e.tag, "_valid"}, bus.out_valid, 1);
      checkVal({e.tag, "_latency"}, lat, e.lat);
      checkFlags(e);
      checkVal({e.tag, "_inready_done"}, bus.in_ready, 0);
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk); #1;
         checkVal({e.tag, "_hold_valid"}, bus.out_valid, 1);
         checkVal({e.tag, "_hold_inready"}, bus.in_ready, 0);
         checkFlags(e);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkVal({e.tag, "_inready_after"}, bus.in_ready, 1);
      checkVal({e.tag, "_valid_after"}, bus.out_valid, 0);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.ALUControl = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      checkVal("reset_inready", bus.in_ready, 1);
      checkVal("reset_valid", bus.out_valid, 0);
      checkVal("reset_result", bus.result, 0);
      checkVal("reset_flags", {bus.zero, bus.negative, bus.overflow, bus.carry}, 4'b0000);
      checkVal("reset_cmp", {bus.hs, bus.ls, bus.hi, bus.lo}, 4'b0101);
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] add / sub");
      applyStimulus(3'd0, 4'b0111, 4'b0001, "add_ovf");  checkOutput(0);
      applyStimulus(3'd0, 4'b1111, 4'b0001, "add_carry"); checkOutput(0);
      applyStimulus(3'd1, 4'b0101, 4'b0101, "sub_eq");   checkOutput(0);
      applyStimulus(3'd1, 4'b0011, 4'b0101, "sub_lt");   checkOutput(0);
      applyStimulus(3'd1, 4'b1000, 4'b0001, "sub_ovf");  checkOutput(0);

      $display("[TB] logic / slt");
      applyStimulus(3'd2, 4'b1100, 4'b1010, "and");      checkOutput(0);
      applyStimulus(3'd3, 4'b1100, 4'b0010, "or");       checkOutput(0);
      applyStimulus(3'd5, 4'b1000, 4'b0001, "slt_true"); checkOutput(0);
      applyStimulus(3'd5, 4'b0011, 4'b1110, "slt_false"); checkOutput(0);

      $display("[TB] multiply / divide");
      applyStimulus(3'd6, 4'b0101, 4'b0011, "mul_15");   checkOutput(0);
      applyStimulus(3'd6, 4'b1000, 4'b0011, "mul_hi");   checkOutput(0);
      applyStimulus(3'd7, 4'b1101, 4'b0011, "div_13_3"); checkOutput(0);
      applyStimulus(3'd7, 4'b0110, 4'b0000, "div_zero"); checkOutput(0);
      applyStimulus(3'd7, 4'b1111, 4'b1111, "div_self"); checkOutput(0);
      applyStimulus(3'd6, 4'b1111, 4'b1111, "mul_max");  checkOutput(0);

      $display("[TB] backpressure");
      applyStimulus(3'd4, 4'b1010, 4'b0110, "xor_hold"); checkOutput(10);

      $display("[TB] reset during multiply");
      applyStimulus(3'd6, 4'b0111, 4'b0011, "mul_abort");
      // This request is abandoned by the reset, so its expectation is dropped
      sb.delete(sb.size() - 1);
      @(posedge clk); #1;
      checkVal("abort_busy_inready", bus.in_ready, 0);
      checkVal("abort_busy_valid", bus.out_valid, 0);
      rst_n = 1'b0;
      #1;
      checkVal("abort_valid", bus.out_valid, 0);
      checkVal("abort_inready", bus.in_ready, 1);
      checkVal("abort_result", bus.result, 0);
      checkVal("abort_cmp", {bus.hs, bus.ls, bus.hi, bus.lo}, 4'b0101);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(3'd0, 4'b0001, 4'b0001, "add_after_rst"); checkOutput(0);
      applyStimulus(3'd6, 4'b0011, 4'b0011, "mul_after_rst"); checkOutput(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, registered successor to the combinational ula/comparator pair. Accepts one operation per transaction over a valid/ready handshake. Single-cycle ops: add, sub, and, or, xor, slt. Iterative ops: unsigned multiply (shift-add) and unsigned divide (restoring). Result, NZCV flags and unsigned-compare outputs (hs/ls/hi/lo) are registered and held until the consumer takes them.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 2 and up.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ALUControl  input  3  operation select
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  Z flag
carry  output  1  C flag
overflow  output  1  V flag
negative  output  1  N flag
hs  output  1  unsigned a>=b (carry)
ls  output  1  unsigned a<=b (~carry | zero)
hi  output  1  unsigned a>b (carry & ~zero)
lo  output  1  unsigned a<b (~carry)

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0.
  - result=0 and all flags 0.
  - hs/ls/hi/lo follow the combinational rules from the reset flags: lo=1, ls=1, hs=0, hi=0.
- FSM states: IDLE, BUSY, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- IDLE:
  - Accept occurs on in_valid & in_ready at a clock edge; a, b and ALUControl are captured.
  - Single-cycle op: result and flags are written at the accept edge; go to DONE. Latency 1 cycle (out_valid high the cycle after accept).
  - Iterative op (110/111): load operands, clear iteration counter, go to BUSY.
- BUSY:
  - One iteration per cycle for exactly WIDTH cycles.
  - At the edge completing iteration WIDTH: write result and flags, go to DONE. Latency WIDTH+1 cycles from accept to out_valid.
  - in_valid is ignored.
- DONE:
  - result and flags are held stable.
  - On out_valid & out_ready: go to IDLE.
  - No accept occurs in the same cycle; the next accept is earliest one cycle later.
- ALUControl encoding (all arithmetic mod 2^WIDTH):
  - 000 add: C = carry out of the MSB; V = signed overflow.
  - 001 sub (a + ~b + 1): C = no-borrow (1 when a>=b unsigned); V = signed overflow.
  - 010 and, 011 or, 100 xor: C=0, V=0.
  - 101 slt: result = 1 if signed a<b, else 0. C and V are taken from the internal a-b subtraction, so compare outputs remain valid.
  - 110 mul: result = low WIDTH bits of a*b. C=1 iff the high WIDTH bits are nonzero. V=0.
  - 111 divu: result = a/b (quotient). C=0, V=0.
  - Divide by zero (b==0): result = all ones, V=1, C=0; still takes WIDTH cycles.
- Flags for every op: Z = (result==0); N = result[WIDTH-1].
- hs/ls/hi/lo are pure functions of the registered carry/zero flags. They are meaningful after sub or slt.
- Reset asserted mid-BUSY or in DONE: immediate return to IDLE; the partial result is discarded; outputs take reset values.
- out_ready held low: DONE persists indefinitely with outputs unchanged.
- A single-cycle op must not disturb the iteration counter/accumulator state of a later iterative op; each accept fully reinitialises it.

Test Plan:
1. WIDTH=4, add a=0111, b=0001 -> next cycle result=1000, N=1, V=1, C=0, Z=0, out_valid=1.
2. WIDTH=4, sub a=0101, b=0101 -> result=0000, Z=1, C=1, hs=1, ls=1, hi=0, lo=0. Then sub a=0011, b=0101 -> result=1110, C=0, lo=1, N=1.
3. WIDTH=4, mul a=0101, b=0011 -> out_valid exactly 5 cycles after accept, result=1111, C=0. Then mul a=1000, b=0011 -> result=1000, C=1.
4. WIDTH=4, divu a=1101, b=0011 -> result=0100 after 5 cycles. Then divu a=0110, b=0000 -> result=1111, V=1.
5. Backpressure: keep out_ready=0 for 10 cycles after an xor (a=1010, b=0110, result=1100) -> result and flags stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 the next cycle.
6. Assert rst_n=0 during BUSY of a mul -> out_valid=0, in_ready=1, result=0 immediately. After release, a new add a=0001, b=0001 -> result=0010.
